floor_scroller: RTL and testbench
=================================

FLOOR_SCROLLER -- requirements
Module: floor_scroller

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 3, meaning the number of floors, range 2..8.
REQ-002 SHALL have parameter FIRST_Y, default 100, meaning the reset y of floor 0.
REQ-003 SHALL have parameter FLOOR_SPACING, default 150, meaning the vertical pitch between floors; must be greater than 4.
REQ-004 SHALL have parameter FLOOR_THICK, default 8, meaning floor height in lines.
REQ-005 SHALL have parameter GAP_MIN, default 32, meaning the minimum gap width in pixels.
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the LFSR reset value; 0 is replaced by 1.
REQ-007 SHALL have parameter FLOOR_RGB, default 8'b000_111_01, meaning floor colour {r,g,b}.
REQ-008 SHALL have port clk, input, 1 bit: single clock (pixel clock domain).
REQ-009 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port frame, input, 1 bit: one-cycle pulse per frame.
REQ-011 SHALL have port start, input, 1 bit: level; begins scrolling.
REQ-012 SHALL have port pause, input, 1 bit: level; freezes scrolling.
REQ-013 SHALL have port speed, input, 2 bits: scroll step minus 1 (step = speed+1 px/frame).
REQ-014 SHALL have port hc, input, 10 bits: current pixel column.
REQ-015 SHALL have port vc, input, 10 bits: current pixel row.
REQ-016 SHALL have port red, output, 3 bits: floor pixel red.
REQ-017 SHALL have port green, output, 3 bits: floor pixel green.
REQ-018 SHALL have port blue, output, 2 bits: floor pixel blue.
REQ-019 SHALL have port floors_y, output, 10*NUM_FLOORS bits: floor y positions, floor 0 in LSBs.
REQ-020 SHALL have port gaps_x, output, 10*NUM_FLOORS bits: gap left edges.
REQ-021 SHALL have port gaps_w, output, 10*NUM_FLOORS bits: gap widths.
REQ-022 SHALL have port wrap, output, 1 bit: one-cycle pulse when a floor is recycled.
REQ-023 SHALL have port score, output, 8 bits: recycled-floor count.
REQ-024 SHALL have port state, output, 2 bits: FSM state (00 IDLE, 01 RUN, 10 PAUSE).

Function
REQ-025 FSM SHALL transition IDLE->RUN on start=1, RUN->PAUSE on pause=1, and PAUSE->RUN on pause=0; IDLE ignores pause.
REQ-026 FSM transitions SHALL take effect on the clock edge sampling the input, independent of frame.
REQ-027 Floor y, LFSR, score and wrap SHALL update only on a frame=1 cycle while state=RUN.
REQ-028 speed SHALL be sampled in the same frame=1 cycle as the move it controls.
REQ-029 On such an update, each floor with y >= step SHALL get y <= y - step.
REQ-030 On such an update, each floor with y < step SHALL get y <= y + NUM_FLOORS*FLOOR_SPACING - step (wrap), using 11-bit intermediate arithmetic and truncation to 10 bits.
REQ-031 A wrapping floor SHALL get gap_x <= 64 + lfsr[8:0] and gap_w <= GAP_MIN + 2*lfsr[12:9], using the LFSR value before its advance in that cycle.
REQ-032 On a wrap, wrap SHALL be 1 for exactly that cycle and score SHALL increment, saturating at 255.
REQ-033 At most one floor wraps per update (guaranteed by FLOOR_SPACING > 4); if several wrap anyway, all SHALL take the same gap values and score SHALL increment by 1.
REQ-034 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, shifting left with feedback into bit 0, advancing once per RUN update.
REQ-035 A pixel SHALL be floor when hc<640, vc<480, floor_y <= vc < floor_y+FLOOR_THICK for any floor, and not gap_x <= hc < gap_x+gap_w for that floor.
REQ-036 Floor-pixel comparisons SHALL use 11-bit sums so no wrap-around occurs.
REQ-037 red/green/blue SHALL be registered with 1-cycle latency from hc/vc, equal to FLOOR_RGB on a floor pixel and 0 otherwise.
REQ-038 floors_y, gaps_x and gaps_w SHALL be direct register outputs.

Reset
REQ-039 On rst=1 at a clock edge, the block SHALL set state=IDLE, floor i y=FIRST_Y+i*FLOOR_SPACING, gap_x[i]=64+128*i, gap_w[i]=GAP_MIN, lfsr=LFSR_SEED (1 if the seed is 0), score=0, wrap=0, rgb=0.
REQ-040 rst SHALL take priority over frame, start and pause, including mid-frame and mid-RUN.

Verification
REQ-041 Defaults, rst released, start=1, speed=0, one frame pulse -> floors_y = 99, 249, 399; wrap=0; state=RUN.
REQ-042 Floor 0 at y=2, speed=3, frame pulse -> floor0 y=448, wrap pulse 1 cycle, score=1, gap_x=64+(0xACE1&0x1FF)=289, gap_w=32+2*((0xACE1>>9)&0xF)=44 (first update after reset).
REQ-043 state=PAUSE or IDLE, 10 frame pulses -> floors_y, LFSR and score unchanged; pause drop -> RUN on the next edge.
REQ-044 Pixel check at reset geometry: vc=100, hc=10 -> rgb=FLOOR_RGB one cycle later; hc=70 (in gap 64..95) -> 0; vc=108 -> 0; hc=700 -> 0.
REQ-045 score at 255 plus a further wrap -> score stays 255 and wrap still pulses.
REQ-046 rst asserted in the same cycle as a frame pulse in RUN -> all reset values hold; no wrap.

Source files
------------

// File: rtl/floor_scroller.sv
// Scrolling-floor generator: floors move up each RUN frame and wrap to the bottom with a new LFSR gap.
// A registered pixel path colours floor pixels, leaving out each floor's gap span.
module floor_scroller #(
    parameter int          NUM_FLOORS    = 3,
    parameter int          FIRST_Y       = 100,
    parameter int          FLOOR_SPACING = 150,
    parameter int          FLOOR_THICK   = 8,
    parameter int          GAP_MIN       = 32,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [7:0]  FLOOR_RGB     = 8'b000_111_01
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame,
    input  logic                      start,
    input  logic                      pause,
    input  logic [1:0]                speed,
    input  logic [9:0]                hc,
    input  logic [9:0]                vc,
    output logic [2:0]                red,
    output logic [2:0]                green,
    output logic [1:0]                blue,
    output logic [10*NUM_FLOORS-1:0]  floors_y,
    output logic [10*NUM_FLOORS-1:0]  gaps_x,
    output logic [10*NUM_FLOORS-1:0]  gaps_w,
    output logic                      wrap,
    output logic [7:0]                score,
    output logic [1:0]                state
);

    localparam int          TOTAL_SPAN = NUM_FLOORS * FLOOR_SPACING;
    localparam logic [15:0] SEED       = (LFSR_SEED == 16'd0) ? 16'd1 : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t      stateReg, stateNext;
    logic [9:0]  floorYReg [NUM_FLOORS];
    logic [9:0]  gapXReg   [NUM_FLOORS];
    logic [9:0]  gapWReg   [NUM_FLOORS];
    logic [9:0]  floorYNext[NUM_FLOORS];
    logic [15:0] lfsrReg;
    logic [7:0]  scoreReg;
    logic        wrapReg;
    logic [7:0]  rgbReg;

    logic [NUM_FLOORS-1:0] wrapHit;
    logic [NUM_FLOORS-1:0] floorHit;
    logic                  update;
    logic                  anyWrap;
    logic [10:0]           step;
    logic [9:0]            newGapX;
    logic [9:0]            newGapW;
    logic [15:0]           lfsrNext;
    logic                  floorPix;

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start)  stateNext = RUN;
            RUN:     if (pause)  stateNext = PAUSE;
            PAUSE:   if (!pause) stateNext = RUN;
            default: stateNext = IDLE;
        endcase
    end

    assign update   = frame && (stateReg == RUN);
    assign step     = 11'(speed) + 11'd1;
    assign anyWrap  = |wrapHit;
    // Gap values come from the LFSR value held before this update's advance
    assign newGapX  = 10'd64 + {1'b0, lfsrReg[8:0]};
    assign newGapW  = 10'(GAP_MIN) + {5'd0, lfsrReg[12:9], 1'b0};
    assign lfsrNext = {lfsrReg[14:0], lfsrReg[15] ^ lfsrReg[13] ^ lfsrReg[12] ^ lfsrReg[10]};

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            logic [10:0] wrapSum;
            logic [10:0] yEnd;
            logic [10:0] gapEnd;
            logic        inRow;
            logic        inGap;

            assign wrapHit[gi]    = {1'b0, floorYReg[gi]} < step;
            assign wrapSum        = {1'b0, floorYReg[gi]} + 11'(TOTAL_SPAN) - step;
            assign floorYNext[gi] = wrapHit[gi] ? wrapSum[9:0] : (floorYReg[gi] - step[9:0]);

            // Widened sums keep floors and gaps near the 10-bit limit from aliasing
            assign yEnd   = {1'b0, floorYReg[gi]} + 11'(FLOOR_THICK);
            assign gapEnd = {1'b0, gapXReg[gi]} + {1'b0, gapWReg[gi]};
            assign inRow  = ({1'b0, vc} >= {1'b0, floorYReg[gi]}) && ({1'b0, vc} < yEnd);
            assign inGap  = ({1'b0, hc} >= {1'b0, gapXReg[gi]}) && ({1'b0, hc} < gapEnd);
            assign floorHit[gi] = inRow && !inGap;

            assign floors_y[gi*10 +: 10] = floorYReg[gi];
            assign gaps_x[gi*10 +: 10]   = gapXReg[gi];
            assign gaps_w[gi*10 +: 10]   = gapWReg[gi];
        end
    endgenerate

    assign floorPix = (hc < 10'd640) && (vc < 10'd480) && (|floorHit);

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= IDLE;
            lfsrReg  <= SEED;
            scoreReg <= 8'd0;
            wrapReg  <= 1'b0;
            rgbReg   <= 8'd0;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                floorYReg[i] <= 10'(FIRST_Y + i * FLOOR_SPACING);
                gapXReg[i]   <= 10'(64 + 128 * i);
                gapWReg[i]   <= 10'(GAP_MIN);
            end
        end else begin
            stateReg <= stateNext;
            rgbReg   <= floorPix ? FLOOR_RGB : 8'd0;
            wrapReg  <= update && anyWrap;
            if (update) begin
                lfsrReg <= lfsrNext;
                if (anyWrap && (scoreReg != 8'd255))
                    scoreReg <= scoreReg + 8'd1;
                for (int i = 0; i < NUM_FLOORS; i++) begin
                    floorYReg[i] <= floorYNext[i];
                    if (wrapHit[i]) begin
                        gapXReg[i] <= newGapX;
                        gapWReg[i] <= newGapW;
                    end
                end
            end
        end
    end

    assign state = stateReg;
    assign wrap  = wrapReg;
    assign score = scoreReg;
    assign red   = rgbReg[7:5];
    assign green = rgbReg[4:2];
    assign blue  = rgbReg[1:0];

endmodule

// File: tb/tb_floor_scroller.sv
// Directed bench for floor_scroller: pixel vector table, FSM sequences, wrap/gap draw, score saturation.
`timescale 1ns/1ps
module tb_floor_scroller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame = 1'b0;
    logic        frame2 = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic [9:0]  hc = 10'd0;
    logic [9:0]  vc = 10'd0;

    logic [2:0]  red, green, red2, green2;
    logic [1:0]  blue, blue2;
    logic [29:0] floorsY, gapsX, gapsW, floorsY2, gapsX2, gapsW2;
    logic        wrap, wrap2;
    logic [7:0]  score, score2;
    logic [1:0]  state, state2;

    int checks = 0;
    int errors = 0;

    floor_scroller dut (
        .clk(clk), .rst(rst), .frame(frame), .start(start), .pause(pause), .speed(speed),
        .hc(hc), .vc(vc), .red(red), .green(green), .blue(blue),
        .floors_y(floorsY), .gaps_x(gapsX), .gaps_w(gapsW),
        .wrap(wrap), .score(score), .state(state)
    );

    // Second instance starts floor 0 at y=2 so its first update wraps immediately
    floor_scroller #(.FIRST_Y(2)) dut2 (
        .clk(clk), .rst(rst), .frame(frame2), .start(start), .pause(pause), .speed(speed),
        .hc(hc), .vc(vc), .red(red2), .green(green2), .blue(blue2),
        .floors_y(floorsY2), .gaps_x(gapsX2), .gaps_w(gapsW2),
        .wrap(wrap2), .score(score2), .state(state2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] hc;
        logic [9:0] vc;
        logic [7:0] rgb;
    } pix_vec_t;

    pix_vec_t vecs[16];

    // Reference model of the default-parameter instance
    logic [9:0]  yM[3];
    logic [9:0]  gxM[3];
    logic [9:0]  gwM[3];
    logic [15:0] lfsrM;
    logic [7:0]  scoreM;
    logic        wrapM;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] pack3(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2);
        return {a2, a1, a0};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            yM[i]  = 10'(100 + 150 * i);
            gxM[i] = 10'(64 + 128 * i);
            gwM[i] = 10'd32;
        end
        lfsrM  = 16'hACE1;
        scoreM = 8'd0;
        wrapM  = 1'b0;
    endtask

    task automatic modelStep(input int stepPx);
        logic [10:0] s;
        wrapM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (int'(yM[i]) >= stepPx) begin
                yM[i] = yM[i] - 10'(stepPx);
            end else begin
                s = 11'(yM[i]) + 11'd450 - 11'(stepPx);
                yM[i] = s[9:0];
                gxM[i] = 10'd64 + 10'(lfsrM[8:0]);
                gwM[i] = 10'd32 + 10'(2 * lfsrM[12:9]);
                wrapM = 1'b1;
            end
        end
        lfsrM = {lfsrM[14:0], lfsrM[15] ^ lfsrM[13] ^ lfsrM[12] ^ lfsrM[10]};
        if (wrapM && scoreM != 8'd255) scoreM = scoreM + 8'd1;
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_floorsY"}, 32'(floorsY), 32'(pack3(10'd100, 10'd250, 10'd400)));
        chk({tag, "_gapsX"}, 32'(gapsX), 32'(pack3(10'd64, 10'd192, 10'd320)));
        chk({tag, "_gapsW"}, 32'(gapsW), 32'(pack3(10'd32, 10'd32, 10'd32)));
        chk({tag, "_score"}, 32'(score), 32'd0);
        chk({tag, "_wrap"}, 32'(wrap), 32'd0);
    endtask

    initial begin
        logic sawSatWrap;
        int   errBefore;
        int   stepPx;

        vecs[0]  = '{10'd10,  10'd100, 8'b000_111_01};
        vecs[1]  = '{10'd70,  10'd100, 8'd0};
        vecs[2]  = '{10'd10,  10'd108, 8'd0};
        vecs[3]  = '{10'd700, 10'd100, 8'd0};
        vecs[4]  = '{10'd10,  10'd107, 8'b000_111_01};
        vecs[5]  = '{10'd63,  10'd100, 8'b000_111_01};
        vecs[6]  = '{10'd64,  10'd100, 8'd0};
        vecs[7]  = '{10'd95,  10'd104, 8'd0};
        vecs[8]  = '{10'd96,  10'd104, 8'b000_111_01};
        vecs[9]  = '{10'd10,  10'd99,  8'd0};
        vecs[10] = '{10'd191, 10'd250, 8'b000_111_01};
        vecs[11] = '{10'd192, 10'd250, 8'd0};
        vecs[12] = '{10'd224, 10'd257, 8'b000_111_01};
        vecs[13] = '{10'd400, 10'd403, 8'b000_111_01};
        vecs[14] = '{10'd639, 10'd100, 8'b000_111_01};
        vecs[15] = '{10'd640, 10'd100, 8'd0};

        modelReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chkReset("reset");
        chk("reset_rgb", 32'({red, green, blue}), 32'd0);

        // Pixel table at reset geometry; output lags hc/vc by one edge
        for (int i = 0; i < 16; i++) begin
            hc = vecs[i].hc;
            vc = vecs[i].vc;
            tick();
            chk($sformatf("pix%0d_h%0d_v%0d", i, vecs[i].hc, vecs[i].vc),
                32'({red, green, blue}), 32'(vecs[i].rgb));
        end
        hc = 10'd0;
        vc = 10'd0;

        // IDLE ignores pause and frames
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frame = 1'b1; tick(); frame = 1'b0; tick();
        end
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_floorsY", 32'(floorsY), 32'(pack3(10'd100, 10'd250, 10'd400)));
        pause = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_state", 32'(state), 32'd1);

        // First update of the y=2 instance wraps floor 0 with gap from the seed
        speed = 2'd3;
        frame2 = 1'b1; tick(); frame2 = 1'b0;
        chk("wrap1_floorsY", 32'(floorsY2), 32'(pack3(10'd448, 10'd148, 10'd298)));
        chk("wrap1_pulse", 32'(wrap2), 32'd1);
        chk("wrap1_score", 32'(score2), 32'd1);
        chk("wrap1_gapX", 32'(gapsX2[9:0]), 32'd289);
        chk("wrap1_gapW", 32'(gapsW2[9:0]), 32'd44);
        tick();
        chk("wrap1_pulseEnd", 32'(wrap2), 32'd0);

        speed = 2'd0;
        frame = 1'b1; tick(); frame = 1'b0;
        modelStep(1);
        chk("run1_floorsY", 32'(floorsY), 32'(pack3(10'd99, 10'd249, 10'd399)));
        chk("run1_wrap", 32'(wrap), 32'd0);
        chk("run1_state", 32'(state), 32'd1);

        // PAUSE freezes motion; any LFSR drift shows up in later gap checks
        pause = 1'b1;
        tick();
        chk("pause_state", 32'(state), 32'd2);
        for (int i = 0; i < 10; i++) begin
            frame = 1'b1; tick(); frame = 1'b0; tick();
        end
        chk("pause_floorsY", 32'(floorsY), 32'(pack3(10'd99, 10'd249, 10'd399)));
        chk("pause_score", 32'(score), 32'd0);
        pause = 1'b0;
        tick();
        chk("resume_state", 32'(state), 32'd1);

        // Long run with varying speed until a wrap occurs with score already at 255
        sawSatWrap = 1'b0;
        errBefore = errors;
        for (int n = 0; n < 20000 && !sawSatWrap && errors == errBefore; n++) begin
            speed = 2'(n % 4);
            stepPx = (n % 4) + 1;
            if (scoreM == 8'd255) begin
                modelStep(stepPx);
                sawSatWrap = wrapM;
            end else begin
                modelStep(stepPx);
            end
            frame = 1'b1; tick(); frame = 1'b0;
            chk("run_floorsY", 32'(floorsY), 32'(pack3(yM[0], yM[1], yM[2])));
            chk("run_gapsX", 32'(gapsX), 32'(pack3(gxM[0], gxM[1], gxM[2])));
            chk("run_gapsW", 32'(gapsW), 32'(pack3(gwM[0], gwM[1], gwM[2])));
            chk("run_wrap", 32'(wrap), 32'(wrapM));
            chk("run_score", 32'(score), 32'(scoreM));
            tick();
            chk("run_wrapLow", 32'(wrap), 32'd0);
        end
        if (errors == errBefore) begin
            chk("sat_reached", 32'(sawSatWrap), 32'd1);
            chk("sat_score", 32'(score), 32'd255);
        end

        // Reset wins over a simultaneous frame and start while running
        chk("prerst_state", 32'(state), 32'd1);
        speed = 2'd3;
        rst = 1'b1; frame = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; frame = 1'b0; start = 1'b0;
        chkReset("rstPrio");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
